uart_rs232_rx: RTL
==================

UART_RS232_RX -- requirements
Module: uart_rs232_rx

Interface
REQ-001 Parameters SHALL be: OVERSAMPLE, default 16, Tick pulses per bit; SYNC_STAGES, default 2, flip-flop stages in the Rx input synchroniser.
REQ-002 Ports SHALL be:
- Clk  in  1  system clock; all logic rising-edge on Clk.
- Rst_n  in  1  reset, asynchronous, active-low.
- Tick  in  1  one-Clk-wide enable pulse at OVERSAMPLE x baud; sole timebase, never used as a clock.
- RxEn  in  1  receiver enable; low holds the FSM in IDLE.
- NBits  in  4  data bits per frame, 5..8.
- Rx  in  1  asynchronous serial line, idle high.
- RxData  out  8  received word, right-aligned, upper bits zero.
- RxDone  out  1  one-Clk pulse when a frame completes.
- RxBusy  out  1  high in every state except IDLE.
- FrameErr  out  1  stop bit sampled low; valid with RxDone.

Function
REQ-003 Rx SHALL pass through SYNC_STAGES flip-flops (reset value 1) before any use; all later references to Rx mean the synchronised value.
REQ-004 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-005 IDLE -> START SHALL occur on the Clk cycle after a high-to-low transition of Rx while RxEn=1; the tick counter SHALL clear and NBits SHALL be latched.
REQ-006 A latched NBits outside 5..8 SHALL be treated as 8.
REQ-007 START SHALL count Ticks; on the Tick that brings the count to OVERSAMPLE/2 (the 8th), Rx=0 -> DATA with counter cleared; Rx=1 -> IDLE (glitch reject, no RxDone).
REQ-008 DATA SHALL sample Rx on every OVERSAMPLE-th Tick (bit centre) and shift it into an 8-bit register from the MSB side, so the word is LSB-first.
REQ-009 After NBits samples, DATA SHALL go to PARITY when the macro is defined, otherwise to STOP.
REQ-010 STOP SHALL sample Rx on the OVERSAMPLE-th Tick.
REQ-011 On that stop sample, on the same Clk edge:
- RxData SHALL load shift_reg >> (8-NBits).
- RxDone SHALL pulse for exactly one Clk.
- FrameErr SHALL load the inverse of the sample.
REQ-012 After the stop sample, the FSM SHALL go to IDLE if Rx=1, and to BREAK if Rx=0.
REQ-013 BREAK SHALL wait for Rx=1, then go to IDLE; no new start is detected until then.
REQ-014 RxData and FrameErr SHALL hold their values until the next RxDone.
REQ-015 Tick cycles SHALL be the only cycles on which counters advance; a Tick coinciding with a state entry SHALL be counted.
REQ-016 If RxEn drops mid-frame, the FSM SHALL return to IDLE on the next Clk without pulsing RxDone, and RxData SHALL be unchanged.
REQ-017 Worst-case latency from the stop-bit centre Tick to RxDone SHALL be 1 Clk.

Reset
REQ-018 Rst_n low SHALL force asynchronously: state IDLE, counters 0, shift register 0, RxData 0, RxDone 0, RxBusy 0, FrameErr 0, ParityErr 0, synchroniser stages 1.
REQ-019 Reset asserted mid-frame SHALL discard the frame; after release, reception SHALL restart only on a new falling edge.

Configuration
REQ-020 When UART_RX_PARITY_EN is defined:
- Port ParityErr (out, 1) SHALL exist.
- PARITY SHALL sample one bit on the OVERSAMPLE-th Tick.
- ParityErr SHALL load with RxDone, set when the XOR of the data bits and the parity bit is 1 (even parity).
REQ-021 When UART_RX_PARITY_EN is undefined, there SHALL be no ParityErr port and no PARITY state, and frames SHALL be start + NBits + stop.

Structure
REQ-022 A shared package uart_pkg SHALL hold the state enumeration, the default OVERSAMPLE, and the NBits min/max constants (5, 8).
REQ-023 The synchroniser SHALL be a sub-module, uart_rx_sync, parameterised by SYNC_STAGES; all other logic SHALL be in one file.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- NBits=8, frame 0xA5, good stop -> RxData=0xA5, one RxDone pulse, FrameErr=0.
- NBits=5, bits 1,0,1,1,0 LSB-first -> RxData=0x0D.
- Rx low for 4 Ticks then high -> FSM back to IDLE, no RxDone, RxBusy low again.
- Frame 0x3C with stop bit low, line held low 40 Ticks -> RxDone with FrameErr=1, stays in BREAK until Rx high; next frame 0x11 -> RxData=0x11, FrameErr=0.
- Rst_n pulsed during bit 3 of 0xFF -> all outputs 0; following frame 0x42 -> RxData=0x42.
- UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> RxData=0x07, ParityErr=1; with parity bit 1 -> ParityErr=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state enumeration and shared constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam logic [3:0] NBITS_MIN = 4'd5;
  localparam logic [3:0] NBITS_MAX = 4'd8;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rx_state_t;
  function automatic logic [3:0] eff_nbits(input logic [3:0] n);
    return (n < NBITS_MIN || n > NBITS_MAX) ? NBITS_MAX : n;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep synchroniser for the serial line, resetting to idle-high.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) ff <= '1;
    else ff <= (ff << 1) | SYNC_STAGES'(d);
  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rs232_rx.sv
// uart_rs232_rx: oversampled RS-232 receiver, LSB-first, 5..8 data bits.
// Define UART_RX_PARITY_EN to add an even-parity bit and the ParityErr output.
module uart_rs232_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick,
  input  logic       RxEn,
  input  logic [3:0] NBits,
  input  logic       Rx,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       RxBusy,
`ifdef UART_RX_PARITY_EN
  output logic       ParityErr,
`endif
  output logic       FrameErr
);
  localparam int CW = $clog2(OVERSAMPLE + 1);
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0] bit_cnt, bit_cnt_n, nbits_q, nbits_n;
  logic [7:0] shift, shift_n, data_n;
  logic rx_s, rx_d, done_n, ferr_n, bit_tick, half_tick;
`ifdef UART_RX_PARITY_EN
  logic par, par_n, perr_n;
`endif
  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.Clk(Clk), .Rst_n(Rst_n), .d(Rx), .q(rx_s));
  assign cnt_inc   = cnt + CW'(Tick);
  assign bit_tick  = Tick && cnt_inc == CW'(OVERSAMPLE);
  assign half_tick = Tick && cnt_inc == CW'(OVERSAMPLE / 2);
  assign RxBusy    = state != IDLE;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      nbits_q  <= NBITS_MAX;
      shift    <= '0;
      rx_d     <= 1'b1;
      RxData   <= '0;
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par       <= 1'b0;
      ParityErr <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      nbits_q  <= nbits_n;
      shift    <= shift_n;
      rx_d     <= rx_s;
      RxData   <= data_n;
      RxDone   <= done_n;
      FrameErr <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par       <= par_n;
      ParityErr <= perr_n;
`endif
    end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt_inc;
    bit_cnt_n = bit_cnt;
    nbits_n   = nbits_q;
    shift_n   = shift;
    data_n    = RxData;
    done_n    = 1'b0;
    ferr_n    = FrameErr;
`ifdef UART_RX_PARITY_EN
    par_n  = par;
    perr_n = ParityErr;
`endif
    if (!RxEn) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s) begin
          // a Tick landing on the detection cycle is already the first counted Tick
          state_n   = START;
          cnt_n     = CW'(Tick);
          nbits_n   = eff_nbits(NBits);
          shift_n   = '0;
          bit_cnt_n = '0;
        end
      end
      START: if (half_tick) begin
        state_n = rx_s ? IDLE : DATA;
        cnt_n   = '0;
      end
      DATA: if (bit_tick) begin
        cnt_n     = '0;
        shift_n   = {rx_s, shift[7:1]};
        bit_cnt_n = bit_cnt + 4'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_cnt_n == nbits_q) state_n = PARITY;
`else
        if (bit_cnt_n == nbits_q) state_n = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_tick) begin
        cnt_n   = '0;
        par_n   = rx_s;
        state_n = STOP;
      end
`endif
      STOP: if (bit_tick) begin
        cnt_n   = '0;
        data_n  = shift >> (4'd8 - nbits_q);
        done_n  = 1'b1;
        ferr_n  = !rx_s;
`ifdef UART_RX_PARITY_EN
        perr_n  = ^shift ^ par;
`endif
        state_n = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
